// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// width of the read-latency down-counter.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Wide enough to hold RD_LAT-1 for RD_LAT up to 4.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into a fetched word (little-endian lanes).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [4:0]  byte_sel;
   logic [4:0]  half_sel;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_sel    = {offset_i, 3'b000};
      half_sel    = {offset_i[1], 4'b0000};
      byte_v      = word_i[byte_sel +: 8];
      half_v      = word_i[half_sel +: 16];
      load_data_o = word_i;
      merged_o    = store_data_i;
      case (size_i)
         SZ_BYTE: begin
            load_data_o = {{24{signed_i & byte_v[7]}}, byte_v};
            merged_o    = word_i;
            merged_o[byte_sel +: 8] = store_data_i[7:0];
         end
         SZ_HALF: begin
            load_data_o = {{16{signed_i & half_v[15]}}, half_v};
            merged_o    = word_i;
            merged_o[half_sel +: 16] = store_data_i[15:0];
         end
         default: begin
            load_data_o = word_i;
            merged_o    = store_data_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus initiator for the word-addressed data memory, with
// read-modify-write for sub-word stores. Optional LSU_MISALIGN_TRAP_EN
// reports misaligned half/word accesses instead of force-aligning them.
//
// state   | meaning
// S_IDLE  | req_ready=1, waiting for a request
// S_READ  | mem_read held for RD_LAT cycles, word captured on the last
// S_WRITE | mem_write for one cycle
// S_RESP  | rsp_valid pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_read_data
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic              write_q, write_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]        req_size_n;
   logic [1:0]        req_off_n;
   logic              misalign;
   logic [31:0]       load_data;
   logic [31:0]       merged;

   lsu_lane_align u_lane_align (
      .word_i       (mem_read_data),
      .offset_i     (off_q),
      .size_i       (size_q),
      .signed_i     (signed_q),
      .store_data_i (wdata_q),
      .load_data_o  (load_data),
      .merged_o     (merged)
   );

   always_comb begin
      req_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;
      case (req_size_n)
         SZ_BYTE: req_off_n = req_addr[1:0];
         SZ_HALF: req_off_n = {req_addr[1], 1'b0};
         default: req_off_n = 2'b00;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                 ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      size_d      = size_q;
      signed_d    = signed_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr[ADDR_W+1:2];
               off_d    = req_off_n;
               size_d   = req_size_n;
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata;
               rdata_d  = 32'h0;
               err_d    = 1'b0;
               cnt_d    = CNT_INIT;
               if (misalign) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (req_write && (req_size_n == SZ_WORD)) begin
                  mem_wdata_d = req_wdata;
                  state_d     = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            if (cnt_q == '0) begin
               if (write_q) begin
                  mem_wdata_d = merged;
                  state_d     = S_WRITE;
               end else begin
                  rdata_d = load_data;
                  state_d = S_RESP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WRITE: state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         off_q       <= 2'b00;
         size_q      <= SZ_BYTE;
         signed_q    <= 1'b0;
         write_q     <= 1'b0;
         wdata_q     <= 32'h0;
         mem_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign req_ready      = (state_q == S_IDLE);
   assign mem_read       = (state_q == S_READ);
   assign mem_write      = (state_q == S_WRITE);
   assign rsp_valid      = (state_q == S_RESP);
   assign rsp_rdata      = rdata_q;
   assign rsp_err        = err_q;
   assign mem_address    = addr_q;
   assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit against a small word-addressed memory.
module tb_load_store_unit;

   localparam int ADDR_W = 18;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_signed = 1'b0;
   logic [ADDR_W+1:0] req_addr = '0;
   logic [31:0]       req_wdata = 32'h0;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_write_data;
   logic              mem_write;
   logic              mem_read;
   logic [31:0]       mem_read_data;

   load_store_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   assign mem_read_data = mem[mem_address[7:0]];
   always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

   int n_tests = 0;
   int n_fail  = 0;

   int          got_lat, n_rd, n_wr, busy_bad, both_bad;
   logic [31:0] got_waddr, got_wdata, got_raddr, got_rdata;
   logic        got_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [19:0] addr, input logic [31:0] wd);
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_wdata = 32'h0;
      got_lat = 0; n_rd = 0; n_wr = 0; busy_bad = 0; both_bad = 0;
      got_waddr = 32'hx; got_wdata = 32'hx; got_raddr = 32'hx;
      got_rdata = 32'hx; got_err = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_read && mem_write) both_bad++;
         if (mem_read) begin n_rd++; got_raddr = 32'(mem_address); end
         if (mem_write) begin
            n_wr++; got_waddr = 32'(mem_address); got_wdata = mem_write_data;
         end
         if (rsp_valid) begin
            got_lat = k; got_rdata = rsp_rdata; got_err = rsp_err;
            break;
         end
         if (req_ready) busy_bad++;
      end
      if (got_lat == 0) chk("timeout_rsp", 32'd0, 32'd1);
      chk("ready_low_busy", 32'(busy_bad), 32'd0);
      chk("rd_wr_overlap", 32'(both_bad), 32'd0);
   endtask

   task automatic chk_txn(input string tag, input int lat, input int nrd, input int nwr,
                          input logic [31:0] rd, input logic e);
      chk({tag, "_lat"},   32'(got_lat), 32'(lat));
      chk({tag, "_nrd"},   32'(n_rd),    32'(nrd));
      chk({tag, "_nwr"},   32'(n_wr),    32'(nwr));
      chk({tag, "_rdata"}, got_rdata,    rd);
      chk({tag, "_err"},   32'(got_err), 32'(e));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready",      32'(req_ready),      32'd1);
      chk("rst_rsp_valid",  32'(rsp_valid),      32'd0);
      chk("rst_rsp_err",    32'(rsp_err),        32'd0);
      chk("rst_mem_read",   32'(mem_read),       32'd0);
      chk("rst_mem_write",  32'(mem_write),      32'd0);
      chk("rst_rsp_rdata",  rsp_rdata,           32'd0);
      chk("rst_mem_addr",   32'(mem_address),    32'd0);
      chk("rst_mem_wdata",  mem_write_data,      32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_req(1'b1, 2'b10, 1'b0, 20'h8, 32'hFEFDFBF7);
      chk_txn("wst", 2, 0, 1, 32'h0, 1'b0);
      chk("wst_addr",  got_waddr, 32'd2);
      chk("wst_wdata", got_wdata, 32'hFEFDFBF7);

      run_req(1'b0, 2'b10, 1'b0, 20'h8, 32'h0);
      chk_txn("wld", RD_LAT + 1, RD_LAT, 0, 32'hFEFDFBF7, 1'b0);
      chk("wld_addr", got_raddr, 32'd2);

      run_req(1'b0, 2'b00, 1'b1, 20'hB, 32'h0);
      chk_txn("lbs", RD_LAT + 1, RD_LAT, 0, 32'hFFFFFFFE, 1'b0);
      run_req(1'b0, 2'b00, 1'b0, 20'hB, 32'h0);
      chk_txn("lbu", RD_LAT + 1, RD_LAT, 0, 32'h000000FE, 1'b0);

      run_req(1'b1, 2'b10, 1'b0, 20'h10, 32'h11223344);
      chk_txn("pre4", 2, 0, 1, 32'h0, 1'b0);
      run_req(1'b1, 2'b01, 1'b0, 20'h12, 32'h00003FFF);
      chk_txn("sh", RD_LAT + 2, RD_LAT, 1, 32'h0, 1'b0);
      chk("sh_addr",  got_waddr, 32'd4);
      chk("sh_wdata", got_wdata, 32'h3FFF3344);

      run_req(1'b1, 2'b00, 1'b0, 20'h11, 32'h123456AB);
      chk_txn("sb", RD_LAT + 2, RD_LAT, 1, 32'h0, 1'b0);
      chk("sb_wdata", got_wdata, 32'h3FFFAB44);

      run_req(1'b0, 2'b01, 1'b1, 20'h10, 32'h0);
      chk_txn("lhs", RD_LAT + 1, RD_LAT, 0, 32'hFFFFAB44, 1'b0);
      run_req(1'b0, 2'b01, 1'b0, 20'h10, 32'h0);
      chk_txn("lhu", RD_LAT + 1, RD_LAT, 0, 32'h0000AB44, 1'b0);
      run_req(1'b0, 2'b01, 1'b1, 20'h12, 32'h0);
      chk_txn("lhs_pos", RD_LAT + 1, RD_LAT, 0, 32'h00003FFF, 1'b0);
      run_req(1'b0, 2'b00, 1'b1, 20'h13, 32'h0);
      chk_txn("lbs_pos", RD_LAT + 1, RD_LAT, 0, 32'h0000003F, 1'b0);

      run_req(1'b1, 2'b10, 1'b0, 20'h4, 32'h55AA0011);
      chk_txn("pre1", 2, 0, 1, 32'h0, 1'b0);
      run_req(1'b0, 2'b10, 1'b0, 20'h6, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk_txn("mis", 1, 0, 0, 32'h0, 1'b1);
`else
      chk_txn("mis", RD_LAT + 1, RD_LAT, 0, 32'h55AA0011, 1'b0);
      chk("mis_addr", got_raddr, 32'd1);
`endif

      run_req(1'b0, 2'b11, 1'b1, 20'h8, 32'h0);
      chk_txn("sz11", RD_LAT + 1, RD_LAT, 0, 32'hFEFDFBF7, 1'b0);

      // Abort a byte store during its read phase; memory must keep the old word.
      run_req(1'b1, 2'b10, 1'b0, 20'h20, 32'h01020304);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 20'h21; req_wdata = 32'h000000FF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_read_on", 32'(mem_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_read_off",  32'(mem_read),  32'd0);
      chk("abort_write_off", 32'(mem_write), 32'd0);
      chk("abort_rsp_off",   32'(rsp_valid), 32'd0);
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (mem_write || mem_read || rsp_valid) bad++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (mem_write || mem_read || rsp_valid || !req_ready) bad++;
      end
      chk("abort_quiet", 32'(bad), 32'd0);
      run_req(1'b0, 2'b10, 1'b0, 20'h20, 32'h0);
      chk_txn("abort_mem", RD_LAT + 1, RD_LAT, 0, 32'h01020304, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
